// File: rtl/chunked_serial_adder_pkg.sv
// Shared definitions for the chunked serial adder: FSM state encoding and
// the helper that derives how many slice cycles one operation takes.
package chunked_serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of CHUNK-wide slices needed to cover a WIDTH-bit operand.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Request/result bundle of the chunked serial adder. The master side issues
// operands and Start; the slave side (the adder) returns Busy/Done and results.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CarryIN;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             CarryOUT;
  logic             Overflow;

  modport master (
    output Start, Sub, A, B, CarryIN,
    input  Busy, Done, Sum, CarryOUT, Overflow
  );

  modport slave (
    input  Start, Sub, A, B, CarryIN,
    output Busy, Done, Sum, CarryOUT, Overflow
  );
endinterface

// File: rtl/chunked_serial_adder_adder_slice.sv
// Combinational W-bit ripple slice. Besides the carry out it exposes the
// carry into the top bit so the caller can form the signed overflow flag.
module adder_slice #(
  parameter int W = 2
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         CarryIN,
  output logic [W-1:0] Sum,
  output logic         CarryOUT,
  output logic         MsbCarry
);

  logic carry;

  // Ripple the carry bit by bit, capturing it just before the MSB is added.
  always_comb begin
    Sum      = '0;
    MsbCarry = 1'b0;
    carry    = CarryIN;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) begin
        MsbCarry = carry;
      end
      Sum[i] = A[i] ^ B[i] ^ carry;
      carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    CarryOUT = carry;
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-wide slice is reused NCHUNK times,
// LSB chunk first, with the slice carry registered between cycles.
module chunked_serial_adder
  import chunked_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic                  clk,
  input logic                  reset,
  chunked_serial_adder_if.slave bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = $clog2(NCHUNK + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             done_reg;

  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_msb_carry;
  logic             last_chunk;

  logic [WIDTH+CHUNK-1:0] shift_cat;

  adder_slice #(
    .W(CHUNK)
  ) u_slice (
    .A        (a_reg[CHUNK-1:0]),
    .B        (b_reg[CHUNK-1:0]),
    .CarryIN  (carry_reg),
    .Sum      (slice_sum),
    .CarryOUT (slice_cout),
    .MsbCarry (slice_msb_carry)
  );

  // The new slice result enters at the top; after NCHUNK shifts the first
  // chunk has reached bit 0, so the register holds the assembled result.
  assign shift_cat  = {slice_sum, res_reg};
  assign res_next   = shift_cat[WIDTH+CHUNK-1:CHUNK];
  assign last_chunk = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave IDLE on Start, return after the final chunk.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.Start) state_next = RUN;
      RUN:  if (last_chunk) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-chunk shifting and result publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            a_reg     <= bus.A;
            b_reg     <= bus.B ^ {WIDTH{bus.Sub}};
            carry_reg <= bus.Sub ? 1'b1 : bus.CarryIN;
            idx       <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> CHUNK;
          b_reg     <= b_reg >> CHUNK;
          carry_reg <= slice_cout;
          res_reg   <= res_next;
          if (last_chunk) begin
            sum_reg  <= res_next;
            cout_reg <= slice_cout;
            ovf_reg  <= slice_msb_carry ^ slice_cout;
            done_reg <= 1'b1;
            idx      <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy     = (state == RUN);
  assign bus.Done     = done_reg;
  assign bus.Sum      = sum_reg;
  assign bus.CarryOUT = cout_reg;
  assign bus.Overflow = ovf_reg;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for the chunked serial adder in four configurations:
// 8/2 (main), 4/2 (exhaustive against a model), 8/8 and 8/1 (latency).
module tb_chunked_serial_adder;

  logic clk;
  logic reset;

  int testsRun    = 0;
  int testsFailed = 0;

  chunked_serial_adder_if #(.WIDTH(8)) if82 ();
  chunked_serial_adder_if #(.WIDTH(4)) if42 ();
  chunked_serial_adder_if #(.WIDTH(8)) if88 ();
  chunked_serial_adder_if #(.WIDTH(8)) if81 ();

  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut82 (.clk(clk), .reset(reset), .bus(if82));
  chunked_serial_adder #(.WIDTH(4), .CHUNK(2)) dut42 (.clk(clk), .reset(reset), .bus(if42));
  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut88 (.clk(clk), .reset(reset), .bus(if88));
  chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) dut81 (.clk(clk), .reset(reset), .bus(if81));

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some sequence never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setInputs(input int dut, input logic st, input logic sub,
                           input logic [7:0] a, input logic [7:0] b, input logic cin);
    case (dut)
      0: begin if82.Start = st; if82.Sub = sub; if82.A = a; if82.B = b; if82.CarryIN = cin; end
      1: begin if42.Start = st; if42.Sub = sub; if42.A = a[3:0]; if42.B = b[3:0]; if42.CarryIN = cin; end
      2: begin if88.Start = st; if88.Sub = sub; if88.A = a; if88.B = b; if88.CarryIN = cin; end
      default: begin if81.Start = st; if81.Sub = sub; if81.A = a; if81.B = b; if81.CarryIN = cin; end
    endcase
  endtask

  function automatic logic [7:0] getSum(input int dut);
    case (dut)
      0: return if82.Sum;
      1: return {4'b0000, if42.Sum};
      2: return if88.Sum;
      default: return if81.Sum;
    endcase
  endfunction

  function automatic logic [2:0] getFlags(input int dut);
    // {Busy, CarryOUT, Overflow}
    case (dut)
      0: return {if82.Busy, if82.CarryOUT, if82.Overflow};
      1: return {if42.Busy, if42.CarryOUT, if42.Overflow};
      2: return {if88.Busy, if88.CarryOUT, if88.Overflow};
      default: return {if81.Busy, if81.CarryOUT, if81.Overflow};
    endcase
  endfunction

  function automatic logic getDone(input int dut);
    case (dut)
      0: return if82.Done;
      1: return if42.Done;
      2: return if88.Done;
      default: return if81.Done;
    endcase
  endfunction

  // One full operation: Start for one edge, then wait (bounded) for Done.
  // Returns edges from the Start edge to Done and the number of Busy samples.
  task automatic applyStimulus(input int dut, input logic sub, input logic [7:0] a,
                               input logic [7:0] b, input logic cin,
                               output int lat, output int busyCnt);
    @(negedge clk);
    setInputs(dut, 1'b1, sub, a, b, cin);
    @(posedge clk);
    lat = 0;
    busyCnt = 0;
    @(negedge clk);
    setInputs(dut, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    while (!getDone(dut) && lat < 20) begin
      busyCnt += int'(getFlags(dut)[2]);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  logic [7:0] obsSum;
  logic [2:0] obsFlags;
  int lat;
  int busyCnt;
  int doneCnt;

  initial begin
    setInputs(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    setInputs(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    setInputs(2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    setInputs(3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state of every configuration.
    for (int d = 0; d < 4; d++) begin
      checkOutput("reset_sum", 32'(getSum(d)), 32'h0);
      checkOutput("reset_flags_done", 32'({getFlags(d), getDone(d)}), 32'h0);
    end

    // Main 8/2 directed vectors: {CarryOUT, Overflow, Sum}.
    applyStimulus(0, 1'b0, 8'h5A, 8'h33, 1'b0, lat, busyCnt);
    checkOutput("add_5a_33_latency", 32'(lat), 32'd4);
    checkOutput("add_5a_33_busy", 32'(busyCnt), 32'd4);
    checkOutput("add_5a_33_result", 32'({getFlags(0)[1:0], getSum(0)}), {22'b0, 2'b01, 8'h8D});
    checkOutput("add_5a_33_done", 32'(getDone(0)), 32'd1);

    applyStimulus(0, 1'b0, 8'hFF, 8'h01, 1'b1, lat, busyCnt);
    checkOutput("add_ff_01_c1", 32'({getFlags(0)[1:0], getSum(0)}), {22'b0, 2'b10, 8'h01});

    applyStimulus(0, 1'b1, 8'h10, 8'h20, 1'b1, lat, busyCnt);
    checkOutput("sub_10_20", 32'({getFlags(0)[1:0], getSum(0)}), {22'b0, 2'b00, 8'hF0});

    applyStimulus(0, 1'b1, 8'h80, 8'h01, 1'b0, lat, busyCnt);
    checkOutput("sub_80_01", 32'({getFlags(0)[1:0], getSum(0)}), {22'b0, 2'b11, 8'h7F});

    // Start held through RUN with changing operands: one Done, result of first operands.
    @(negedge clk);
    setInputs(0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0);
    @(posedge clk);
    @(negedge clk);
    if82.A = 8'hAA;
    if82.B = 8'h55;
    doneCnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 2) begin
        checkOutput("hold_sum_during_run", 32'(getSum(0)), 32'h7F);
      end
      if (i == 3) begin
        if82.Start = 1'b0;
      end
      doneCnt += int'(getDone(0));
    end
    checkOutput("held_start_single_done", 32'(doneCnt), 32'd1);
    checkOutput("held_start_sum", 32'(getSum(0)), 32'h02);

    // Reset during RUN: everything cleared, no Done afterwards.
    @(negedge clk);
    setInputs(0, 1'b1, 1'b0, 8'h5A, 8'h33, 1'b0);
    @(posedge clk);
    @(negedge clk);
    if82.Start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrun_reset_sum", 32'(getSum(0)), 32'h0);
    checkOutput("midrun_reset_flags_done", 32'({getFlags(0), getDone(0)}), 32'h0);
    doneCnt = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      doneCnt += int'(getDone(0));
    end
    checkOutput("midrun_reset_no_done", 32'(doneCnt), 32'd0);

    // Start presented in the Done cycle is accepted.
    applyStimulus(0, 1'b0, 8'h01, 8'h02, 1'b0, lat, busyCnt);
    checkOutput("pre_backtoback_sum", 32'(getSum(0)), 32'h03);
    setInputs(0, 1'b1, 1'b0, 8'h03, 8'h04, 1'b0);
    @(posedge clk);
    @(negedge clk);
    setInputs(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("backtoback_busy", 32'({getFlags(0)[2], getDone(0)}), 32'b10);
    lat = 0;
    while (!getDone(0) && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput("backtoback_latency", 32'(lat), 32'd4);
    checkOutput("backtoback_sum", 32'(getSum(0)), 32'h07);

    // CHUNK = WIDTH: single RUN cycle.
    applyStimulus(2, 1'b0, 8'h7F, 8'h01, 1'b0, lat, busyCnt);
    checkOutput("c8_latency", 32'(lat), 32'd1);
    checkOutput("c8_result", 32'({getFlags(2)[1:0], getSum(2)}), {22'b0, 2'b01, 8'h80});

    // CHUNK = 1: eight RUN cycles.
    applyStimulus(3, 1'b1, 8'hC8, 8'h64, 1'b0, lat, busyCnt);
    checkOutput("c1_latency", 32'(lat), 32'd8);
    checkOutput("c1_result", 32'({getFlags(3)[1:0], getSum(3)}), {22'b0, 2'b11, 8'h64});

    // 4/2 exhaustive sweep against a behavioural two's-complement model.
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int a = 0; a < 16; a++) begin
          for (int b = 0; b < 16; b++) begin
            logic [3:0] a4;
            logic [3:0] bb;
            logic       ci;
            logic [4:0] full;
            logic       ovf;
            a4   = 4'(a);
            bb   = (s == 1) ? ~4'(b) : 4'(b);
            ci   = (s == 1) ? 1'b1 : c[0];
            full = {1'b0, a4} + {1'b0, bb} + {4'b0, ci};
            ovf  = (a4[3] == bb[3]) && (full[3] != a4[3]);
            applyStimulus(1, s[0], 8'(a), 8'(b), c[0], lat, busyCnt);
            checkOutput("sweep_w4c2", 32'({lat[3:0], getFlags(1)[1:0], getSum(1)}),
                        {18'b0, 4'd2, full[4], ovf, 4'b0000, full[3:0]});
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
